// File: rtl/polar_encoder_if.sv
// polar_encoder_if: info-bit stream, frozen-bit ROM port and coded-bit stream of the polar encoder
interface polar_encoder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  s_axi_tdata;
  logic                  s_axi_tvalid;
  logic                  s_axi_tlast;
  logic                  s_axi_tready;
  logic                  frozen_rd_en;
  logic [ADDR_WIDTH-1:0] frozen_rd_addr;
  logic                  frozen_rd_data;
  logic                  m_axi_tdata;
  logic                  m_axi_tvalid;
  logic                  m_axi_tready;
  logic                  m_axi_tlast;
  logic                  error;
  modport slave (
    input  s_axi_tdata, s_axi_tvalid, s_axi_tlast, frozen_rd_data, m_axi_tready,
    output s_axi_tready, frozen_rd_en, frozen_rd_addr, m_axi_tdata, m_axi_tvalid, m_axi_tlast, error
  );
  modport master (
    output s_axi_tdata, s_axi_tvalid, s_axi_tlast, frozen_rd_data, m_axi_tready,
    input  s_axi_tready, frozen_rd_en, frozen_rd_addr, m_axi_tdata, m_axi_tvalid, m_axi_tlast, error
  );
endinterface

// File: rtl/polar_encoder.sv
// polar_encoder: frozen-bit insertion, n-stage in-place butterfly x = u*F^n, 1-bit AXI-Stream output
// Define POLAR_ENCODER_BIT_REVERSE_EN to emit the codeword in bit-reversed index order.
module polar_encoder #(
  parameter int CODE_LENGTH        = 1024,
  parameter int FROZEN_BITS_LENGTH = 48,
  parameter int ADDR_WIDTH         = $clog2(CODE_LENGTH)
) (
  input logic            clk,
  input logic            reset,
  polar_encoder_if.slave bus
);
  localparam int N = CODE_LENGTH;
  localparam int SW = $clog2(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] K = (ADDR_WIDTH + 1)'(CODE_LENGTH - FROZEN_BITS_LENGTH);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    FETCH  = 5'b00010,
    FILL   = 5'b00100,
    ENCODE = 5'b01000,
    OUTPUT = 5'b10000
  } state_t;

  state_t                          state, state_nxt;
  logic [ADDR_WIDTH-1:0]           idx, idx_nxt, pos, pos_nxt, pos_adv, sel;
  logic [ADDR_WIDTH:0]             cnt, cnt_nxt, cnt_inc;
  logic [SW-1:0]                   stage, stage_nxt;
  logic [N-1:0]                    u, u_nxt, enc;
  logic [ADDR_WIDTH-1:0][N-1:0]    stage_out;
  logic                            trunc, trunc_nxt, err, err_nxt, tready;
  logic                            tdata, tdata_nxt, tvalid, tvalid_nxt, tlast, tlast_nxt;

  // every butterfly stage is built; the stage counter picks which one updates u
  for (genvar s = 0; s < ADDR_WIDTH; s++) begin : g_stage
    for (genvar j = 0; j < N; j++) begin : g_bit
      if (((j >> s) & 1) == 1) begin : g_hi
        assign stage_out[s][j] = u[j];
      end else begin : g_lo
        assign stage_out[s][j] = u[j] ^ u[j + 2 ** s];
      end
    end
  end

  assign enc = stage_out[stage];
  assign cnt_inc = cnt + 1'b1;
  assign tready = (state == FILL) && !bus.frozen_rd_data && !trunc;
  assign pos_adv = (state == OUTPUT) ? pos + 1'b1 : '0;
`ifdef POLAR_ENCODER_BIT_REVERSE_EN
  assign sel = {<<{pos_adv}};
`else
  assign sel = pos_adv;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    cnt_nxt = cnt;
    u_nxt = u;
    trunc_nxt = trunc;
    err_nxt = err;
    stage_nxt = stage;
    pos_nxt = pos;
    tdata_nxt = tdata;
    tvalid_nxt = tvalid;
    tlast_nxt = tlast;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        cnt_nxt = '0;
        u_nxt = '0;
        trunc_nxt = 1'b0;
        stage_nxt = '0;
        state_nxt = FETCH;
      end
      FETCH: state_nxt = FILL;
      FILL: if (!tready || bus.s_axi_tvalid) begin
        // frozen and truncated positions keep the zero written in IDLE
        if (tready) begin
          u_nxt[idx] = bus.s_axi_tdata;
          cnt_nxt = cnt_inc;
          if (bus.s_axi_tlast != (cnt_inc == K)) begin
            err_nxt = 1'b1;
            trunc_nxt = bus.s_axi_tlast;
          end
        end
        idx_nxt = idx + 1'b1;
        state_nxt = (idx == LAST_IDX) ? ENCODE : FETCH;
      end
      ENCODE: begin
        u_nxt = enc;
        stage_nxt = stage + 1'b1;
        if (stage == LAST_STAGE) begin
          state_nxt = OUTPUT;
          pos_nxt = '0;
          tvalid_nxt = 1'b1;
          tdata_nxt = enc[sel];
          tlast_nxt = 1'b0;
        end
      end
      OUTPUT: if (bus.m_axi_tready) begin
        if (pos == LAST_IDX) begin
          state_nxt = IDLE;
          tvalid_nxt = 1'b0;
          tdata_nxt = 1'b0;
          tlast_nxt = 1'b0;
        end else begin
          pos_nxt = pos_adv;
          tdata_nxt = u[sel];
          tlast_nxt = pos_adv == LAST_IDX;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      u <= '0;
      trunc <= 1'b0;
      err <= 1'b0;
      stage <= '0;
      pos <= '0;
      tdata <= 1'b0;
      tvalid <= 1'b0;
      tlast <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      u <= u_nxt;
      trunc <= trunc_nxt;
      err <= err_nxt;
      stage <= stage_nxt;
      pos <= pos_nxt;
      tdata <= tdata_nxt;
      tvalid <= tvalid_nxt;
      tlast <= tlast_nxt;
    end
  end

  assign bus.s_axi_tready = tready;
  assign bus.frozen_rd_en = state == FETCH;
  assign bus.frozen_rd_addr = idx;
  assign bus.m_axi_tdata = tdata;
  assign bus.m_axi_tvalid = tvalid;
  assign bus.m_axi_tlast = tlast;
  assign bus.error = err;
endmodule

// File: tb/tb_polar_encoder.sv
// tb_polar_encoder: N=8 polar encoder bench; frame model from the x_j = XOR{u_i : (i&j)==j} rule
module tb_polar_encoder;
  localparam int N = 8;
  localparam int F = 4;
  localparam int AW = 3;
  localparam int K = N - F;
`ifdef POLAR_ENCODER_BIT_REVERSE_EN
  localparam logic [7:0] X_U3 = 8'b10101010;
  localparam logic [7:0] X_U35 = 8'b01100110;
`else
  localparam logic [7:0] X_U3 = 8'b11110000;
  localparam logic [7:0] X_U35 = 8'b00111100;
`endif
  localparam logic [7:0] X_ALL = 8'b01101001;

  typedef struct packed {logic d; logic l;} beat_t;

  logic clk = 0;
  logic reset = 0;
  logic [N-1:0] frozen_mask = 8'b00010111;
  beat_t mq[$];
  beat_t exp_q[$];
  logic exp_err_q[$];
  int tlast_cyc[$];
  bit model_err = 0;
  int tests = 0, fails = 0, frames_done = 0, cyc = 0, beat_cnt = 0, stall_left = 0, stall_seen = 0;
  logic [N-1:0] last_frame = '0;
  logic held_v = 0, held_d, held_l;
  beat_t e;

  always #5 clk = ~clk;

  polar_encoder_if #(.ADDR_WIDTH(AW)) bus ();

  polar_encoder #(.CODE_LENGTH(N), .FROZEN_BITS_LENGTH(F), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always @(posedge clk) if (bus.frozen_rd_en) bus.frozen_rd_data <= frozen_mask[bus.frozen_rd_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int rev(input int p);
    int r = 0;
    for (int i = 0; i < AW; i++) if (p[i]) r |= 1 << (AW - 1 - i);
    return r;
  endfunction

  // splits the queued beats into frames and predicts every coded beat and the error flag
  task automatic model_run();
    logic [N-1:0] u, x;
    int cnt;
    bit tr;
    beat_t b;
    while (mq.size() > 0) begin
      u = '0;
      cnt = 0;
      tr = 0;
      for (int i = 0; i < N; i++)
        if (!frozen_mask[i] && !tr && mq.size() > 0) begin
          b = mq.pop_front();
          u[i] = b.d;
          cnt++;
          if (b.l && cnt != K) begin
            model_err = 1;
            tr = 1;
          end else if (!b.l && cnt == K) model_err = 1;
        end
      for (int j = 0; j < N; j++) begin
        x[j] = 0;
        for (int i = 0; i < N; i++) if ((i & j) == j) x[j] ^= u[i];
      end
      for (int p = 0; p < N; p++)
`ifdef POLAR_ENCODER_BIT_REVERSE_EN
        exp_q.push_back(beat_t'{x[rev(p)], p == N - 1});
`else
        exp_q.push_back(beat_t'{x[p], p == N - 1});
`endif
      exp_err_q.push_back(model_err);
    end
  endtask

  task automatic send(input logic d, input logic l);
    int n = 0;
    bit hs = 0;
    bus.s_axi_tdata = d;
    bus.s_axi_tlast = l;
    bus.s_axi_tvalid = 1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.s_axi_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("s_axi_handshake_timeout", 0, 1);
  endtask

  task automatic feed(input int nb, input logic [15:0] d, input logic [15:0] l);
    for (int i = 0; i < nb; i++) mq.push_back(beat_t'{d[i], l[i]});
    model_run();
    for (int i = 0; i < nb; i++) send(d[i], l[i]);
    bus.s_axi_tvalid = 0;
    bus.s_axi_tlast = 0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("frames_done", frames_done, target);
    #1;
  endtask

  initial begin
    bus.m_axi_tready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && beat_cnt == 1 && bus.m_axi_tvalid) begin
        bus.m_axi_tready = 0;
        stall_left--;
      end else bus.m_axi_tready = 1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      beat_cnt = 0;
      held_v = 0;
    end else begin
      check("no_input_while_output", bus.s_axi_tready & bus.m_axi_tvalid, 0);
      if (held_v) begin
        check("hold_tvalid", bus.m_axi_tvalid, 1);
        check("hold_tdata", bus.m_axi_tdata, held_d);
        check("hold_tlast", bus.m_axi_tlast, held_l);
      end
      held_v = bus.m_axi_tvalid & !bus.m_axi_tready;
      held_d = bus.m_axi_tdata;
      held_l = bus.m_axi_tlast;
      if (held_v) begin
        stall_seen++;
        if (exp_q.size() > 0) check("stall_tdata", bus.m_axi_tdata, exp_q[0].d);
      end
      if (bus.m_axi_tvalid && bus.m_axi_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("m_tdata", bus.m_axi_tdata, e.d);
          check("m_tlast", bus.m_axi_tlast, e.l);
        end
        last_frame = {last_frame[N-2:0], bus.m_axi_tdata};
        beat_cnt++;
        if (bus.m_axi_tlast) begin
          check("frame_len", beat_cnt, N);
          if (exp_err_q.size() == 0) check("unexpected_frame", 1, 0);
          else check("frame_error", bus.error, exp_err_q.pop_front());
          tlast_cyc.push_back(cyc);
          beat_cnt = 0;
          frames_done++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.s_axi_tvalid = 0;
    bus.s_axi_tdata = 0;
    bus.s_axi_tlast = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", bus.s_axi_tready, 0);
    check("rst_rd_en", bus.frozen_rd_en, 0);
    check("rst_rd_addr", bus.frozen_rd_addr, 0);
    check("rst_m_tvalid", bus.m_axi_tvalid, 0);
    check("rst_m_tdata", bus.m_axi_tdata, 0);
    check("rst_m_tlast", bus.m_axi_tlast, 0);
    check("rst_error", bus.error, 0);
    reset = 1;
    feed(4, 16'b0001, 16'b1000);
    wait_frames(1);
    check("t1_frame", last_frame, X_U3);
    check("t1_error", bus.error, 0);
    stall_left = 3;
    feed(4, 16'b1111, 16'b1000);
    wait_frames(2);
    check("t2_frame", last_frame, X_ALL);
    check("t2_stall_cycles", stall_seen, 3);
    check("t2_error", bus.error, 0);
    feed(2, 16'b11, 16'b10);
    wait_frames(3);
    check("t3_frame", last_frame, X_U35);
    check("t3_error", bus.error, 1);
    feed(4, 16'b0110, 16'b1000);
    wait_frames(4);
    send(1, 0);
    send(1, 0);
    bus.s_axi_tvalid = 0;
    @(posedge clk);
    #1;
    reset = 0;
    model_err = 0;
    @(posedge clk);
    #1;
    check("mid_rst_s_tready", bus.s_axi_tready, 0);
    check("mid_rst_rd_en", bus.frozen_rd_en, 0);
    check("mid_rst_rd_addr", bus.frozen_rd_addr, 0);
    check("mid_rst_m_tvalid", bus.m_axi_tvalid, 0);
    check("mid_rst_m_tdata", bus.m_axi_tdata, 0);
    check("mid_rst_m_tlast", bus.m_axi_tlast, 0);
    check("mid_rst_error", bus.error, 0);
    reset = 1;
    feed(4, 16'b0001, 16'b1000);
    wait_frames(5);
    check("t5_frame", last_frame, X_U3);
    check("t5_error", bus.error, 0);
    feed(8, 16'b00011011, 16'h0080);
    wait_frames(7);
    check("t4_next_frame", last_frame, X_U3);
    check("t4_error", bus.error, 1);
    tlast_cyc.delete();
    feed(12, 16'b1111_0010_1101, 16'b1000_1000_1000);
    wait_frames(10);
    check("t6_frames", tlast_cyc.size(), 3);
    if (tlast_cyc.size() >= 3) begin
      check("t6_period_a", tlast_cyc[1] - tlast_cyc[0], 28);
      check("t6_period_b", tlast_cyc[2] - tlast_cyc[1], 28);
    end
    repeat (5) @(posedge clk);
    check("leftover_beats", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
